// File: rtl/data_unpacker_if.sv
// data_unpacker_if: valid/ready stream carrying one N-lane vector, its chain id and a last marker.
// Latency: none, wires only.
// Backpressure: ready flows from slave to master; a beat transfers when valid and ready are both high.
interface data_unpacker_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CHAIN_W    = 2
);
  logic                             valid;
  logic                             ready;
  logic [CHAIN_W-1:0]               chain_id;
  logic [N-1:0][DATA_WIDTH-1:0]     vector;
  logic                             last;

  modport master (output valid, chain_id, vector, last, input ready);
  modport slave  (input valid, chain_id, vector, output ready);
endinterface

// File: rtl/data_unpacker.sv
// data_unpacker: splits N-lane packed vectors into blocks of N, M or 1 lanes per beat, mode per chain.
// Latency: first block one cycle after accept, then one block per downstream handshake.
// Backpressure: accepts only when empty or on the final beat with downstream ready; output held until taken.
module data_unpacker #(
  parameter int                      N                  = 8,
  parameter int                      M                  = 2,
  parameter int                      DATA_WIDTH         = 32,
  parameter int                      MAX_CHAINS         = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tracing,
  input  logic [7:0]      configId,
  input  logic [7:0]      configData,
  data_unpacker_if.slave  packed_bus,
  data_unpacker_if.master block_bus
);

  localparam int CHAIN_W = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int CNT_W   = $clog2(N + 1);
  localparam logic [CNT_W-1:0] STEP_N = CNT_W'(N);
  localparam logic [CNT_W-1:0] STEP_M = CNT_W'(M);
  localparam logic [CNT_W-1:0] STEP_1 = CNT_W'(1);

  if (M < 1 || M > N || (N % M) != 0) begin : g_bad_m
    $error("data_unpacker: M must be between 1 and N and divide N");
  end

  logic [7:0]                   firmware [MAX_CHAINS];
  logic [7:0]                   byte_counter;
  logic [N-1:0][DATA_WIDTH-1:0] data_buf;
  logic [CNT_W-1:0]             count;
  logic [CNT_W-1:0]             step;
  logic [CHAIN_W-1:0]           chain;

  logic [7:0]       fw_sel;
  logic [CNT_W-1:0] mode_step;
  logic             mode_ok;
  logic             accept;
  logic             beat;

  // Upstream ready: empty, or the current block is the last one and downstream takes it now
  assign packed_bus.ready = !rst && tracing &&
                            ((count == '0) || ((count == step) && block_bus.ready));
  assign accept = packed_bus.valid && packed_bus.ready;
  assign beat   = block_bus.valid && block_bus.ready;

  // Look up the block size for the incoming chain; unknown modes and out-of-range chains drop
  always_comb begin
    fw_sel    = 8'hFF;
    mode_step = STEP_N;
    mode_ok   = 1'b1;
    for (int i = 0; i < MAX_CHAINS; i++) begin
      if (packed_bus.chain_id == CHAIN_W'(i)) fw_sel = firmware[i];
    end
    case (fw_sel)
      8'd0:    mode_step = STEP_N;
      8'd1:    mode_step = STEP_M;
      8'd2:    mode_step = STEP_1;
      default: mode_ok   = 1'b0;
    endcase
  end

  // Vector buffer and remaining-lane count; a new load wins over the shift of the final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      data_buf <= '0;
      count    <= '0;
      step     <= STEP_N;
      chain    <= '0;
    end else if (accept) begin
      if (mode_ok) begin
        data_buf <= packed_bus.vector;
        count    <= STEP_N;
        step     <= mode_step;
        chain    <= packed_bus.chain_id;
      end else begin
        data_buf <= '0;
        count    <= '0;
      end
    end else if (beat) begin
      data_buf <= data_buf >> (int'(step) * DATA_WIDTH);
      count    <= count - step;
    end
  end

  // Firmware bytes arrive in chain order while tracing is off; any other id rewinds the counter
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_counter <= '0;
      for (int i = 0; i < MAX_CHAINS; i++) begin
        firmware[i] <= INITIAL_FIRMWARE[8*i +: 8];
      end
    end else if (!tracing) begin
      if (configId == PERSONAL_CONFIG_ID) begin
        for (int i = 0; i < MAX_CHAINS; i++) begin
          if (byte_counter == 8'(i)) firmware[i] <= configData;
        end
        if (byte_counter != 8'hFF) byte_counter <= byte_counter + 8'd1;
      end else begin
        byte_counter <= '0;
      end
    end
  end

  // Present the low step lanes of the buffer; lanes above the block read as zero
  always_comb begin
    block_bus.vector = '0;
    for (int i = 0; i < N; i++) begin
      if (CNT_W'(i) < step) block_bus.vector[i] = data_buf[i];
    end
  end

  assign block_bus.valid    = (count != '0);
  assign block_bus.last     = (count != '0) && (count == step);
  assign block_bus.chain_id = chain;

endmodule

// File: tb/tb_data_unpacker.sv
// tb_data_unpacker: randomized and directed stimulus against a queue-based reference of the unpacker.
// Latency: expected beats are queued at accept and popped by an independent output monitor.
// Backpressure: downstream ready is scripted in directed tests and random in the soak phase.
module tb_data_unpacker;
  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;
  localparam int MC = 4;
  localparam int CW = 2;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t vec;
    int   ch;
    bit   last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tracing = 1'b1;
  logic [7:0] configId = 8'hFF;
  logic [7:0] configData = 8'h00;

  data_unpacker_if #(.N(N), .DATA_WIDTH(DW), .CHAIN_W(CW)) packed_bus ();
  data_unpacker_if #(.N(N), .DATA_WIDTH(DW), .CHAIN_W(CW)) block_bus ();

  data_unpacker #(
    .N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(MC),
    .PERSONAL_CONFIG_ID(8'd0), .INITIAL_FIRMWARE('0)
  ) dut (
    .clk(clk), .rst(rst), .tracing(tracing),
    .configId(configId), .configData(configData),
    .packed_bus(packed_bus), .block_bus(block_bus)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];
  int    fw_m[MC];
  bit    rnd_rdy = 1'b0;
  logic  rdy_val = 1'b0;
  bit    hold = 1'b0;
  beat_t snap;
  beat_t e;

  function automatic void chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic vec_t seq_vec(input int base);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = DW'(base + i);
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = $urandom;
    return v;
  endfunction

  // Reference: cut the vector into oldest-first blocks of the chain's block size
  function automatic bit push_vec(input int ch, input vec_t v);
    int    size;
    beat_t b;
    case (fw_m[ch])
      0: size = N;
      1: size = M;
      2: size = 1;
      default: return 1'b0;
    endcase
    for (int k = 0; k < N / size; k++) begin
      b.vec = '0;
      for (int j = 0; j < size; j++) b.vec[j] = v[k*size + j];
      b.ch   = ch;
      b.last = (k == N / size - 1);
      exp_q.push_back(b);
    end
    return 1'b1;
  endfunction

  // Single driver of downstream ready, updated just after each rising edge
  initial begin
    block_bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      block_bus.ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    end
  end

  // Output monitor: score every handshake beat and check that a stalled beat stays put
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", block_bus.valid, 1);
        chk("hold_vector", block_bus.vector, snap.vec);
        chk("hold_chain", block_bus.chain_id, snap.ch);
        chk("hold_last", block_bus.last, snap.last);
      end
      hold = 1'b0;
      if (block_bus.valid) begin
        if (block_bus.ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got vector %h chain %0d, expected no beat",
                     block_bus.vector, block_bus.chain_id);
          end else begin
            e = exp_q.pop_front();
            chk("beat_vector", block_bus.vector, e.vec);
            chk("beat_chain", block_bus.chain_id, e.ch);
            chk("beat_last", block_bus.last, e.last);
          end
        end else begin
          snap.vec  = block_bus.vector;
          snap.ch   = int'(block_bus.chain_id);
          snap.last = block_bus.last;
          hold      = 1'b1;
        end
      end
    end
  end

  task automatic send(input int ch, input vec_t v, output int waited);
    bit ok;
    ok     = 1'b0;
    waited = 0;
    packed_bus.valid    = 1'b1;
    packed_bus.chain_id = CW'(ch);
    packed_bus.vector   = v;
    forever begin
      @(negedge clk);
      if (packed_bus.ready) break;
      waited++;
      if (waited > 500) break;
    end
    if (waited > 500) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ready_out low for %0d cycles, expected high", waited);
    end else begin
      ok = push_vec(ch, v);
    end
    @(posedge clk);
    #1;
    packed_bus.valid = 1'b0;
    if (ok) chk("first_block_latency", block_bus.valid, 1);
  endtask

  task automatic cfg_seq(input logic [7:0] bytes [6], input int n);
    int bc;
    tracing  = 1'b0;
    configId = 8'hFF;
    @(posedge clk);
    #1;
    bc = 0;
    for (int i = 0; i < n; i++) begin
      configId   = 8'd0;
      configData = bytes[i];
      @(posedge clk);
      #1;
      if (bc < MC) fw_m[bc] = int'(bytes[i]);
      if (bc < 255) bc++;
    end
    configId = 8'hFF;
    tracing  = 1'b1;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || block_bus.valid) && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("drain_pending_beats", exp_q.size(), 0);
    chk("drain_valid_out", block_bus.valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int           w;
    int           w2;
    int           rem;
    int           pat [7];
    logic [7:0]   bytes [6];
    pat = '{1, 0, 0, 1, 0, 1, 1};
    for (int i = 0; i < MC; i++) fw_m[i] = 0;
    packed_bus.valid    = 1'b0;
    packed_bus.chain_id = '0;
    packed_bus.vector   = '0;
    packed_bus.last     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_out", packed_bus.ready, 0);
    chk("rst_valid_out", block_bus.valid, 0);
    chk("rst_last_out", block_bus.last, 0);
    chk("rst_vector_out", block_bus.vector, 0);
    chk("rst_chain_out", block_bus.chain_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_val = 1'b1;
    @(negedge clk);
    chk("idle_ready_out", packed_bus.ready, 1);
    @(posedge clk);
    #1;

    // Full-width mode, back to back with no upstream stall
    send(0, seq_vec(1), w);
    send(0, seq_vec(9), w2);
    chk("b2b_first_wait", w, 0);
    chk("b2b_second_wait", w2, 0);
    wait_drain();

    // Program modes {2,1,0,7}; extra bytes beyond the chain count are ignored
    bytes = '{8'd2, 8'd1, 8'd0, 8'd7, 8'd9, 8'd9};
    cfg_seq(bytes, 6);

    // Single-value mode on chain 0, then medium blocks on chain 1
    send(0, seq_vec(1), w);
    wait_drain();
    send(1, seq_vec(1), w);
    wait_drain();

    // Chain 3 has an invalid mode: consumed with ready high, nothing emitted
    send(3, seq_vec(100), w);
    chk("drop_wait", w, 0);
    chk("drop_no_output", block_bus.valid, 0);
    @(posedge clk);
    #1;
    chk("drop_still_idle", block_bus.valid, 0);
    send(2, seq_vec(200), w);
    wait_drain();

    // Downstream stalls during a medium-block vector
    rdy_val = 1'b0;
    send(1, seq_vec(50), w);
    rem = 4;
    for (int i = 0; i < 7; i++) begin
      rdy_val = pat[i][0];
      @(negedge clk);
      chk("stall_ready_out", packed_bus.ready, (rem == 1 && pat[i] == 1));
      if (pat[i] == 1) rem--;
      @(posedge clk);
      #1;
    end
    chk("stall_done", block_bus.valid, 0);

    // Reset after two blocks discards the remainder and restores default firmware
    rdy_val = 1'b0;
    send(1, seq_vec(64), w);
    rdy_val = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rdy_val = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_ready_out", packed_bus.ready, 0);
    @(posedge clk);
    #1;
    chk("midrst_valid_out", block_bus.valid, 0);
    chk("midrst_last_out", block_bus.last, 0);
    chk("midrst_vector_out", block_bus.vector, 0);
    chk("midrst_chain_out", block_bus.chain_id, 0);
    rst = 1'b0;
    for (int i = 0; i < MC; i++) fw_m[i] = 0;
    @(negedge clk);
    chk("postrst_ready_out", packed_bus.ready, 1);
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    send(1, seq_vec(300), w);
    wait_drain();

    // Random soak: random modes, chains, data, gaps and downstream ready
    rnd_rdy = 1'b1;
    for (int it = 0; it < 300; it++) begin
      if (it % 60 == 0) begin
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom_range(0, 3));
        cfg_seq(bytes, 4);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send($urandom_range(0, MC - 1), rand_vec(), w);
    end
    rnd_rdy = 1'b0;
    rdy_val = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
